mult_operand_sequencer: RTL and testbench
=========================================

// Module: mult_operand_sequencer
// PURPOSE
//  Control and operand stage directly upstream of the shift-add accumulator (ALU) in the sequential multiplier.
//  - Accepts one unsigned multiply request and drives one partial product per cycle: the multiplicand shifted
//    by the step index, gated by the matching multiplier bit, as A/add_shift. It also drives flush.
//  - Signals done once the accumulator holds the full product.
// PARAMETERS
//  WIDTH_P  32         accumulator/product width; A output width
//  OP_W     WIDTH_P/2  operand width; one RUN step per multiplier bit
// PORTS
//  clk           in   1        rising-edge clock
//  reset_n       in   1        asynchronous, active-low reset
//  start         in   1        request valid; accepted when start && ready
//  multiplicand  in   OP_W     unsigned operand, sampled on accept
//  multiplier    in   OP_W     unsigned operand, sampled on accept
//  abort         in   1        cancel the operation in progress
//  ready         out  1        high only in IDLE
//  busy          out  1        high in CLEAR, RUN, DONE
//  flush         out  1        clear pulse to the accumulator
//  add_shift     out  1        accumulate enable to the accumulator
//  A             out  WIDTH_P  partial product {zeros, multiplicand} << step
//  done          out  1        one-cycle pulse; accumulator result is final in this cycle
// BEHAVIOUR
//  - Reset (reset_n low, asynchronous): state=IDLE. mcand/mplier/step regs=0. ready=1; busy, flush, add_shift, done=0; A=0.
//  - All outputs are registered and decoded from state, step and the latched operands. No combinational input-to-output paths.
//  - FSM states:
//    IDLE : start && ready -> latch operands, step=0, go CLEAR. start while busy is ignored (not queued).
//    CLEAR: flush=1 for exactly one cycle -> RUN.
//    RUN  : A = zero-extend(mcand) << step, add_shift = mplier[step].
//           A is driven every step; A=0 only when add_shift=0. step increments each cycle.
//           step==OP_W-1 -> DONE.
//    DONE : done=1 for one cycle, add_shift=0, A=0 -> IDLE.
//  - Step counter is $clog2(OP_W) bits and never wraps. The exit compare is made on OP_W-1.
//  - Latency: accept edge t0; CLEAR in cycle t0+1; RUN in cycles t0+2..t0+OP_W+1; done in cycle t0+OP_W+2.
//    Next accept is possible in cycle t0+OP_W+3.
//  - Width: A is sized so that mcand << (OP_W-1) fits in WIDTH_P; OP_W <= WIDTH_P/2 is required.
//    The product is unsigned with no truncation.
//  - abort in CLEAR/RUN: next state IDLE, flush=1 for one cycle, add_shift=0, no done.
//    abort in IDLE/DONE is ignored.
//  - abort and start in the same cycle: abort has priority; start is not accepted that cycle.
//  - Operand zero: the full sequence still runs with add_shift never asserted; result=0 and done occurs at the nominal cycle.
//  - reset_n asserted mid-operation: immediate return to IDLE, all outputs at reset values.
//    The accumulator is cleared by its own reset.
// CONFIGURATION
//  - SKIP_ZERO_EN defined: in RUN, if every remaining multiplier bit above step is 0, go to DONE after the current step.
//    Latency = 3 + index of the highest set bit. Multiplier=0 goes CLEAR -> DONE with no RUN cycle.
//  - SKIP_ZERO_EN undefined: fixed latency of OP_W+2 cycles from accept to done, independent of the data.
// TESTING
//  - 3 x 5 (OP_W=16): exactly 2 add_shift pulses with A=3, then A=12.
//    done at accept+18; accumulator reads 15.
//  - 0xFFFF x 0xFFFF: 16 add_shift pulses; the last A is 0x7FFF8000.
//    Accumulator reads 0xFFFE0001 at done.
//  - multiplier=0: flush once, no add_shift; done at accept+18 (accept+2 with SKIP_ZERO_EN); result 0.
//  - start held high through the whole op: a single accept; ready=0 until after done; second accept the cycle after done.
//  - abort at RUN step 5: flush pulse next cycle, IDLE, no done.
//    A new 7 x 9 request then yields 63.
//  - reset_n low at RUN step 8: all outputs at reset values immediately.
//    After release, 2 x 2 yields 4 with nominal latency.

Source files
------------

// File: rtl/mult_operand_sequencer_if.sv
// Request/operand bus between the multiplier front end and the operand sequencer.
interface mult_operand_sequencer_if #(
  parameter int WIDTH_P = 32,
  parameter int OP_W    = WIDTH_P / 2
);
  logic               start;
  logic [OP_W-1:0]    multiplicand;
  logic [OP_W-1:0]    multiplier;
  logic               abort;
  logic               ready;
  logic               busy;
  logic               flush;
  logic               add_shift;
  logic [WIDTH_P-1:0] A;
  logic               done;

  modport master (
    output start, multiplicand, multiplier, abort,
    input  ready, busy, flush, add_shift, A, done
  );

  modport slave (
    input  start, multiplicand, multiplier, abort,
    output ready, busy, flush, add_shift, A, done
  );
endinterface

// File: rtl/mult_operand_sequencer.sv
// Operand/control stage feeding the shift-add accumulator: one gated partial product per RUN cycle.
// Optional SKIP_ZERO_EN: leave RUN early once no multiplier bits remain above the current step.
//
// state | meaning
// IDLE  | ready, waiting for start
// CLEAR | flush pulse to the accumulator
// RUN   | one partial product per cycle, step = multiplier bit index
// DONE  | done pulse, accumulator holds the final product
module mult_operand_sequencer #(
  parameter int WIDTH_P = 32,
  parameter int OP_W    = WIDTH_P / 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mult_operand_sequencer_if.slave bus
);

  localparam int SW = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(OP_W - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t             state;
  logic [OP_W-1:0]    mcand;
  logic [OP_W-1:0]    mplier;
  logic [SW-1:0]      step;

  logic               ready_q;
  logic               busy_q;
  logic               flush_q;
  logic               add_shift_q;
  logic [WIDTH_P-1:0] a_q;
  logic               done_q;

  logic [SW-1:0]      step_nx;
  logic [WIDTH_P-1:0] mcand_ext;
  logic [WIDTH_P-1:0] a_first;
  logic [WIDTH_P-1:0] a_nx;
  logic               last_step;
  logic               skip_all;

  // Next-step operands come only from registers, so outputs never see inputs combinationally.
  assign step_nx   = step + SW'(1);
  assign mcand_ext = {{(WIDTH_P-OP_W){1'b0}}, mcand};
  assign a_first   = mplier[0] ? mcand_ext : '0;
  assign a_nx      = mplier[step_nx] ? (mcand_ext << step_nx) : '0;

`ifdef SKIP_ZERO_EN
  logic [OP_W-1:0] upper_bits;
  assign upper_bits = (mplier >> step) >> 1;
  assign last_step  = (step == LAST_STEP) || (upper_bits == '0);
  assign skip_all   = (mplier == '0);
`else
  assign last_step  = (step == LAST_STEP);
  assign skip_all   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mcand       <= '0;
      mplier      <= '0;
      step        <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      flush_q     <= 1'b0;
      add_shift_q <= 1'b0;
      a_q         <= '0;
      done_q      <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          // abort outranks a same-cycle start
          if (bus.start && !bus.abort) begin
            mcand   <= bus.multiplicand;
            mplier  <= bus.multiplier;
            step    <= '0;
            state   <= CLEAR;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            flush_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (bus.abort) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            flush_q <= 1'b1;
          end else if (skip_all) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state       <= RUN;
            step        <= '0;
            add_shift_q <= mplier[0];
            a_q         <= a_first;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            flush_q     <= 1'b1;
            add_shift_q <= 1'b0;
            a_q         <= '0;
          end else if (last_step) begin
            state       <= DONE;
            done_q      <= 1'b1;
            add_shift_q <= 1'b0;
            a_q         <= '0;
          end else begin
            step        <= step_nx;
            add_shift_q <= mplier[step_nx];
            a_q         <= a_nx;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
          add_shift_q <= 1'b0;
          a_q         <= '0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.flush     = flush_q;
  assign bus.add_shift = add_shift_q;
  assign bus.A         = a_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Randomized bench for mult_operand_sequencer with an arithmetic reference and accumulator model.
module tb_mult_operand_sequencer;
  localparam int WIDTH_P = 32;
  localparam int OP_W    = 16;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  mult_operand_sequencer_if #(.WIDTH_P(WIDTH_P), .OP_W(OP_W)) bus ();

  mult_operand_sequencer #(.WIDTH_P(WIDTH_P), .OP_W(OP_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycles from accept edge to the done cycle.
  function automatic int lat(input logic [15:0] b);
    int hi;
    hi = -1;
    for (int k = 0; k < OP_W; k++) if (b[k]) hi = k;
`ifdef SKIP_ZERO_EN
    return (hi < 0) ? 2 : 3 + hi;
`else
    return OP_W + 2;
`endif
  endfunction

  task automatic do_accept(input logic [15:0] a, input logic [15:0] b);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(posedge clk);
  endtask

  // Follows one operation cycle by cycle from the accept edge; returns at the negedge of the first IDLE cycle.
  task automatic track(input logic [15:0] a, input logic [15:0] b, input bit hold);
    int     l;
    bit     in_run;
    bit     exp_as;
    longint acc;
    l   = lat(b);
    acc = 0;
    for (int c = 1; c <= l + 1; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) bus.start = 1'b0;
      in_run = (c >= 2) && (c < l);
      exp_as = in_run && b[c-2];
      chk("flush", bus.flush, c == 1);
      chk("add_shift", bus.add_shift, exp_as);
      if (exp_as) chk("A", bus.A, longint'(a) * (longint'(1) << (c - 2)));
      else if (!in_run) chk("A_idle", bus.A, 0);
      chk("done", bus.done, c == l);
      chk("busy", bus.busy, c <= l);
      chk("ready", bus.ready, c > l);
      if (bus.flush) acc = 0;
      if (bus.add_shift) acc = (acc + longint'(bus.A)) & 64'hFFFF_FFFF;
      if (c == l) chk("product", acc, longint'(a) * longint'(b));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_flush"}, bus.flush, 0);
    chk({tag, "_add_shift"}, bus.add_shift, 0);
    chk({tag, "_A"}, bus.A, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    int          done_seen;
    n_tests = 0;
    n_fail  = 0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);

    do_accept(16'd3, 16'd5);          track(16'd3, 16'd5, 0);
    do_accept(16'hFFFF, 16'hFFFF);    track(16'hFFFF, 16'hFFFF, 0);
    do_accept(16'h1234, 16'h0000);    track(16'h1234, 16'h0000, 0);
    do_accept(16'h0000, 16'hA5A5);    track(16'h0000, 16'hA5A5, 0);
    do_accept(16'h8001, 16'h0001);    track(16'h8001, 16'h0001, 0);

    // start held across a whole op: second accept lands the cycle after done
    do_accept(16'd11, 16'd13);
    track(16'd11, 16'd13, 1);
    @(posedge clk);
    track(16'd11, 16'd13, 0);

    // abort and start together in IDLE: not accepted
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.multiplicand = 16'd4;
    bus.multiplier   = 16'd4;
    @(negedge clk);
    chk("prio_ready", bus.ready, 1);
    chk("prio_busy", bus.busy, 0);
    chk("prio_flush", bus.flush, 0);
    bus.abort = 1'b0;
    do_accept(16'd4, 16'd4);          track(16'd4, 16'd4, 0);

    // abort at RUN step 5
    a = 16'($urandom);
    b = 16'($urandom) | 16'h8000;
    do_accept(a, b);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 7) bus.abort = 1'b1;
    end
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_flush", bus.flush, 1);
    chk("abort_ready", bus.ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_add_shift", bus.add_shift, 0);
    chk("abort_A", bus.A, 0);
    chk("abort_done", bus.done, 0);
    done_seen = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    do_accept(16'd7, 16'd9);          track(16'd7, 16'd9, 0);

    // reset at RUN step 8
    do_accept(16'hABCD, 16'hFFFF);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_accept(16'd2, 16'd2);          track(16'd2, 16'd2, 0);

    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      case (i % 4)
        0: b = 16'($urandom);
        1: b = 16'($urandom) >> $urandom_range(15, 1);
        2: b = 16'(1) << $urandom_range(15, 0);
        default: b = 16'($urandom) & 16'($urandom);
      endcase
      do_accept(a, b);
      track(a, b, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
